// File: rtl/snn_pkg.sv
// Types and constants shared by the spiking-network blocks.
// CUR_W is the current width that the LIF neuron consumes.
package snn_pkg;
  localparam int CUR_W       = 8;
  localparam int DECAY_SHIFT = 3;

  typedef logic        [CUR_W-1:0] cur_t;
  typedef logic signed [CUR_W-1:0] weight_t;
endpackage

// File: rtl/synapse_weight_sum.sv
// Combinational masked sum of the signed weights of all spiking inputs.
// SW leaves enough headroom that all N_IN weights can be summed without overflow.
module synapse_weight_sum
  import snn_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = CUR_W,
  parameter int SW   = W + $clog2(N_IN) + 2
) (
  input  logic [N_IN-1:0]        spike,
  input  logic [N_IN*W-1:0]      weights,
  output logic signed [SW-1:0]   syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (spike[i]) syn = syn + SW'($signed(weights[i*W +: W]));
    end
  end

endmodule

// File: rtl/synapse_current.sv
// Spike-to-current synapse: weighted spike sum plus shift leak, clamped and registered.
// Weights live in a small register file written through w_we/w_addr/w_data.
module synapse_current
  import snn_pkg::*;
#(
  parameter int N_IN        = 4,
  parameter int W           = CUR_W,
  parameter int DECAY_SHIFT = snn_pkg::DECAY_SHIFT,
  parameter int W_INIT      = 0,
  parameter int AW          = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] spike_in,
  input  logic            leak_en,
  input  logic            w_we,
  input  logic [AW-1:0]   w_addr,
  input  logic [W-1:0]    w_data,
  output logic [W-1:0]    current,
  output logic            sat
);

  localparam int SW = W + $clog2(N_IN) + 2;
  localparam logic signed [SW-1:0] CUR_MAX = SW'({W{1'b1}});

  logic signed [W-1:0]  weight_q [N_IN];
  logic [N_IN*W-1:0]    weights_flat;
  logic signed [SW-1:0] syn;
  logic [W-1:0]         shifted;
  logic [W-1:0]         leak;
  logic signed [SW-1:0] raw;
  logic [W-1:0]         current_next;
  logic                 sat_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) weight_q[i] <= W'(W_INIT);
    end else if (w_we && (32'(w_addr) < N_IN)) begin
      weight_q[w_addr] <= w_data;
    end
  end

  for (genvar g = 0; g < N_IN; g++) begin : g_flat
    assign weights_flat[g*W +: W] = weight_q[g];
  end

  synapse_weight_sum #(
    .N_IN (N_IN),
    .W    (W),
    .SW   (SW)
  ) u_sum (
    .spike   (spike_in),
    .weights (weights_flat),
    .syn     (syn)
  );

  // A nonzero current always leaks at least 1 so decay reaches zero.
  assign shifted = current >> DECAY_SHIFT;

  always_comb begin
    leak = '0;
    if (leak_en) begin
      if ((current != '0) && (shifted == '0)) leak = W'(1);
      else                                    leak = shifted;
    end
  end

  always_comb begin
    raw          = $signed(SW'(current)) - $signed(SW'(leak)) + syn;
    current_next = raw[W-1:0];
    sat_next     = 1'b0;
    if (raw < 0) begin
      current_next = '0;
      sat_next     = 1'b1;
    end else if (raw > CUR_MAX) begin
      current_next = '1;
      sat_next     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current <= '0;
      sat     <= 1'b0;
    end else begin
      current <= current_next;
      sat     <= sat_next;
    end
  end

endmodule

// File: tb/tb_synapse_current.sv
// Bench for synapse_current: directed scenarios plus random traffic, checked
// through an expectation queue against an integer reference model.
module tb_synapse_current;
  localparam int N_IN = 4;
  localparam int W    = 8;
  localparam int DS   = 3;
  localparam int CMAX = (1 << W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_IN-1:0] spike_in;
  logic            leak_en;
  logic            w_we;
  logic [1:0]      w_addr;
  logic [W-1:0]    w_data;
  logic [W-1:0]    current;
  logic            sat;

  synapse_current #(.N_IN(N_IN), .W(W), .DECAY_SHIFT(DS), .W_INIT(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .spike_in (spike_in),
    .leak_en  (leak_en),
    .w_we     (w_we),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .current  (current),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cur;
    bit    sat;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  int   m_cur;
  int   m_w[N_IN];

  // Reference model: plain integer arithmetic, returns the state after one edge.
  task automatic model_step(input bit rst, input bit [N_IN-1:0] sp, input bit lk,
                            input bit we, input int addr, input int data,
                            output int cur_o, output bit sat_o);
    int syn, lv, raw;
    if (rst) begin
      m_cur = 0;
      for (int i = 0; i < N_IN; i++) m_w[i] = 0;
      cur_o = 0;
      sat_o = 0;
      return;
    end
    syn = 0;
    for (int i = 0; i < N_IN; i++) if (sp[i]) syn += m_w[i];
    lv = 0;
    if (lk && m_cur > 0) begin
      lv = m_cur / (1 << DS);
      if (lv == 0) lv = 1;
    end
    raw   = m_cur - lv + syn;
    sat_o = (raw < 0) || (raw > CMAX);
    if (raw < 0)         m_cur = 0;
    else if (raw > CMAX) m_cur = CMAX;
    else                 m_cur = raw;
    if (we && addr < N_IN) m_w[addr] = (data > 127) ? data - 256 : data;
    cur_o = m_cur;
  endtask

  // One clock of stimulus. exp_cur >= 0 pins the expectation to a stated
  // constant; otherwise the model's prediction is used.
  task automatic cycle(input string tag, input bit rst, input bit [N_IN-1:0] sp,
                       input bit lk, input bit we, input int addr, input int data,
                       input int exp_cur = -1, input bit exp_sat = 0);
    exp_t e;
    int   mc;
    bit   ms;
    @(negedge clk);
    reset    = rst;
    spike_in = sp;
    leak_en  = lk;
    w_we     = we;
    w_addr   = 2'(addr);
    w_data   = 8'(data);
    model_step(rst, sp, lk, we, addr, data, mc, ms);
    e.tag = tag;
    if (exp_cur >= 0) begin
      e.cur = exp_cur;
      e.sat = exp_sat;
    end else begin
      e.cur = mc;
      e.sat = ms;
    end
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (int'(current) != e.cur || sat != e.sat) begin
          miscompares++;
          $display("FAIL %s: got current=%0d sat=%0b, want current=%0d sat=%0b",
                   e.tag, current, sat, e.cur, e.sat);
        end
      end
    end
  end

  initial begin : stim
    int wait_cnt;
    reset = 1'b1; spike_in = '0; leak_en = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0;

    // Reset and idle; zero initial weights keep current at 0
    cycle("reset", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle("idle", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)  cycle("all_spike_w0", 0, 4'b1111, 0, 0, 0, 0, 0, 0);

    // Leak plus spike from 200
    cycle("wr_w0_40", 0, 4'b0000, 0, 1, 0, 40, 0, 0);
    for (int i = 1; i <= 5; i++) cycle("preload_200", 0, 4'b0001, 0, 0, 0, 0, 40 * i, 0);
    cycle("leak_spike_215", 0, 4'b0001, 1, 0, 0, 0, 215, 0);

    // Upper clamp from 250
    cycle("reset_b", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    cycle("wr_w0_50", 0, 4'b0000, 0, 1, 0, 50, 0, 0);
    for (int i = 1; i <= 5; i++) cycle("preload_250", 0, 4'b0001, 0, 0, 0, 0, 50 * i, 0);
    cycle("wr_w1_100", 0, 4'b0000, 0, 1, 1, 100, 250, 0);
    cycle("wr_w2_100", 0, 4'b0000, 0, 1, 2, 100, 250, 0);
    cycle("clamp_hi", 0, 4'b0110, 0, 0, 0, 0, 255, 1);
    cycle("hold_255", 0, 4'b0000, 0, 0, 0, 0, 255, 0);

    // Lower clamp from 10 with negative weight
    cycle("reset_c", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    cycle("wr_w0_10", 0, 4'b0000, 0, 1, 0, 10, 0, 0);
    cycle("wr_w3_m50", 0, 4'b0000, 0, 1, 3, 256 - 50, 0, 0);
    cycle("preload_10", 0, 4'b0001, 0, 0, 0, 0, 10, 0);
    cycle("clamp_lo", 0, 4'b1000, 0, 0, 0, 0, 0, 1);

    // Minimum-leak decay from 7 to 0
    cycle("reset_d", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    cycle("wr_w0_7", 0, 4'b0000, 0, 1, 0, 7, 0, 0);
    cycle("preload_7", 0, 4'b0001, 0, 0, 0, 0, 7, 0);
    for (int i = 6; i >= 0; i--) cycle("decay", 0, 4'b0000, 1, 0, 0, 0, i, 0);
    cycle("decay_hold0", 0, 4'b0000, 1, 0, 0, 0, 0, 0);

    // Write and spike on the same index in one cycle
    cycle("reset_e", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    cycle("wr_w0_40b", 0, 4'b0000, 0, 1, 0, 40, 0, 0);
    cycle("old_weight", 0, 4'b0001, 0, 1, 0, 5, 40, 0);
    cycle("new_weight", 0, 4'b0001, 0, 0, 0, 0, 45, 0);

    // Reset beats spikes and writes; weights return to zero
    cycle("reset_f", 1, 4'b0000, 0, 0, 0, 0, 0, 0);
    cycle("wr_w0_45", 0, 4'b0000, 0, 1, 0, 45, 0, 0);
    for (int i = 1; i <= 4; i++) cycle("preload_180", 0, 4'b0001, 0, 0, 0, 0, 45 * i, 0);
    cycle("reset_wins", 1, 4'b1111, 1, 1, 1, 77, 0, 0);
    cycle("weights_cleared", 0, 4'b1111, 0, 0, 0, 0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle("random", ($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, N_IN - 1)),
            int'($urandom_range(0, 255)));
    end
    cycle("final_idle", 0, 4'b0000, 0, 0, 0, 0);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
